// File: rtl/apb_cmd_master.sv
// Single-outstanding APB requester: valid/ready command in, SETUP/ACCESS
// transfer out, valid/ready response back, with an ACCESS-phase timeout.
module apb_cmd_master #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic              cmd_write,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              apb_psel,
  output logic              apb_penable,
  output logic              apb_pwrite,
  output logic [ADDR_W-1:0] apb_paddr,
  output logic [DATA_W-1:0] apb_pwdata,
  input  logic              apb_pready,
  input  logic [DATA_W-1:0] apb_prdata,
  input  logic              apb_pslverr
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } state_e;

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [CW-1:0] CNT_LAST = CW'(LAST);
  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic TO_EN = (TIMEOUT > 0);

  state_e            state_q, state_d;
  logic              up_q;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              write_q, write_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              to_q, to_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      up_q    <= 1'b0;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      up_q    <= 1'b1;
      addr_q  <= addr_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      to_q    <= to_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    write_d = write_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    to_d    = to_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid && up_q) begin
          addr_d  = cmd_addr;
          write_d = cmd_write;
          wdata_d = cmd_write ? cmd_wdata : '0;
          state_d = SETUP;
        end
      end
      SETUP: begin
        cnt_d   = '0;
        state_d = ACCESS;
      end
      ACCESS: begin
        if (apb_pready) begin
          rdata_d = write_q ? '0 : apb_prdata;
          err_d   = apb_pslverr;
          to_d    = 1'b0;
          state_d = RESP;
        end else if (TO_EN && cnt_q == CNT_LAST) begin
          rdata_d = '0;
          err_d   = 1'b1;
          to_d    = 1'b1;
          state_d = RESP;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // up_q keeps cmd_ready low while reset is held
  assign cmd_ready   = up_q && (state_q == IDLE);
  assign apb_psel    = (state_q == SETUP) || (state_q == ACCESS);
  assign apb_penable = (state_q == ACCESS);
  assign rsp_valid   = (state_q == RESP);
  assign apb_pwrite  = write_q;
  assign apb_paddr   = addr_q;
  assign apb_pwdata  = wdata_q;
  assign rsp_rdata   = rdata_q;
  assign rsp_err     = err_q;
  assign rsp_timeout = to_q;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Bench for apb_cmd_master: vector table, random transfers against a
// transaction-level model, timeout, backpressure and reset corners.
module tb_apb_cmd_master;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_addr = '0;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic        apb_psel;
  logic        apb_penable;
  logic        apb_pwrite;
  logic [31:0] apb_paddr;
  logic [31:0] apb_pwdata;
  logic        apb_pready = 1'b0;
  logic [31:0] apb_prdata = '0;
  logic        apb_pslverr = 1'b0;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  apb_cmd_master #(
    .ADDR_W (32),
    .DATA_W (32),
    .TIMEOUT(TO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_addr   (cmd_addr),
    .cmd_write  (cmd_write),
    .cmd_wdata  (cmd_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .rsp_timeout(rsp_timeout),
    .apb_psel   (apb_psel),
    .apb_penable(apb_penable),
    .apb_pwrite (apb_pwrite),
    .apb_paddr  (apb_paddr),
    .apb_pwdata (apb_pwdata),
    .apb_pready (apb_pready),
    .apb_prdata (apb_prdata),
    .apb_pslverr(apb_pslverr)
  );

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wd;
    int          waitc;
    logic [31:0] prd;
    logic        serr;
    int          hold;
    logic [31:0] e_rdata;
    logic        e_err;
    logic        e_to;
    int          e_lat;
    int          e_acc;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic noise;
    apb_pready  = 1'($urandom);
    apb_prdata  = $urandom;
    apb_pslverr = 1'($urandom);
  endtask

  // Transaction-level expectation from the target's behaviour
  task automatic model(input logic wr, input int waitc,
                       input logic [31:0] prd, input logic serr,
                       output logic [31:0] e_rdata, output logic e_err,
                       output logic e_to, output int e_lat,
                       output int e_acc);
    e_to    = (TO != 0) && (waitc >= TO);
    e_err   = e_to || serr;
    e_rdata = (e_to || wr) ? 32'h0 : prd;
    e_acc   = e_to ? TO : waitc + 1;
    e_lat   = e_acc + 2;
  endtask

  task automatic xfer(input vec_t v);
    int lat;
    int acc;
    chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_addr  = v.addr;
    cmd_write = v.wr;
    cmd_wdata = v.wd;
    rsp_ready = 1'b0;
    noise();
    tick();
    lat = 1;
    cmd_valid = 1'b0;
    cmd_addr  = $urandom;
    cmd_write = 1'($urandom);
    cmd_wdata = $urandom;
    chk("setup_psel", {apb_psel, apb_penable, cmd_ready}, 32'b100);
    chk("setup_paddr", apb_paddr, v.addr);
    chk("setup_pwrite", 32'(apb_pwrite), 32'(v.wr));
    chk("setup_pwdata", apb_pwdata, v.wr ? v.wd : 32'h0);
    noise();
    tick();
    lat++;
    acc = 0;
    while (!rsp_valid && lat < 100) begin
      if (apb_psel && apb_penable) begin
        chk("access_paddr", apb_paddr, v.addr);
        chk("access_pwdata", apb_pwdata, v.wr ? v.wd : 32'h0);
        apb_pready  = (acc == v.waitc);
        apb_prdata  = (acc == v.waitc) ? v.prd : $urandom;
        apb_pslverr = (acc == v.waitc) ? v.serr : 1'($urandom);
        acc++;
      end else begin
        noise();
      end
      tick();
      lat++;
    end
    chk("rsp_valid", 32'(rsp_valid), 32'd1);
    chk("rsp_latency", 32'(lat), 32'(v.e_lat));
    chk("access_cycles", 32'(acc), 32'(v.e_acc));
    chk("resp_bus_idle", {apb_psel, apb_penable, cmd_ready}, 32'b000);
    chk("rsp_rdata", rsp_rdata, v.e_rdata);
    chk("rsp_err", 32'(rsp_err), 32'(v.e_err));
    chk("rsp_timeout", 32'(rsp_timeout), 32'(v.e_to));
    for (int h = 0; h < v.hold; h++) begin
      rsp_ready = 1'b0;
      noise();
      tick();
      chk("hold_valid", {rsp_valid, apb_psel, cmd_ready}, 32'b100);
      chk("hold_rdata", rsp_rdata, v.e_rdata);
      chk("hold_flags", {rsp_err, rsp_timeout}, {30'd0, v.e_err, v.e_to});
    end
    rsp_ready = 1'b1;
    noise();
    tick();
    rsp_ready = 1'b0;
    chk("post_rsp", {rsp_valid, apb_psel, cmd_ready}, 32'b001);
  endtask

  initial begin
    vec_t v;
    tbl[0] = '{32'h0000_0010, 1'b1, 32'hDEAD_BEEF, 0, 32'h5555_5555,
               1'b0, 0, 32'h0, 1'b0, 1'b0, 3, 1};
    tbl[1] = '{32'h0100_0004, 1'b0, 32'hFFFF_FFFF, 3, 32'h1234_5678,
               1'b0, 0, 32'h1234_5678, 1'b0, 1'b0, 6, 4};
    tbl[2] = '{32'h0000_0020, 1'b0, 32'h0, 0, 32'hA5A5_A5A5,
               1'b1, 0, 32'hA5A5_A5A5, 1'b1, 1'b0, 3, 1};
    tbl[3] = '{32'h0000_0024, 1'b1, 32'hCAFE_F00D, 1, 32'h1111_1111,
               1'b1, 0, 32'h0, 1'b1, 1'b0, 4, 2};
    tbl[4] = '{32'h0000_0030, 1'b0, 32'h0, 7, 32'h7777_7777,
               1'b0, 0, 32'h7777_7777, 1'b0, 1'b0, 10, 8};
    tbl[5] = '{32'h0000_0040, 1'b0, 32'h0, 1000, 32'h9999_9999,
               1'b0, 0, 32'h0, 1'b1, 1'b1, 10, 8};
    tbl[6] = '{32'h0000_0044, 1'b1, 32'h1357_2468, 2, 32'h0,
               1'b0, 5, 32'h0, 1'b0, 1'b0, 5, 3};

    rst_n = 1'b0;
    repeat (2) tick();
    chk("rst_outputs", {cmd_ready, rsp_valid, apb_psel, apb_penable,
                        apb_pwrite, rsp_err, rsp_timeout}, 32'd0);
    chk("rst_paddr", apb_paddr, 32'h0);
    chk("rst_pwdata", apb_pwdata, 32'h0);
    chk("rst_rdata", rsp_rdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("first_cycle_ready", {cmd_ready, rsp_valid, apb_psel}, 32'b100);

    for (int i = 0; i < 7; i++) begin
      xfer(tbl[i]);
      if (i == 5) begin
        for (int k = 0; k < 3; k++) begin
          apb_pready  = 1'b1;
          apb_pslverr = 1'b1;
          tick();
          chk("late_pready", {rsp_valid, apb_psel, cmd_ready}, 32'b001);
        end
      end
    end

    for (int n = 0; n < 40; n++) begin
      v.addr  = $urandom;
      v.wr    = 1'($urandom);
      v.wd    = $urandom;
      v.waitc = $urandom_range(0, 10);
      v.prd   = $urandom;
      v.serr  = 1'($urandom);
      v.hold  = $urandom_range(0, 2);
      model(v.wr, v.waitc, v.prd, v.serr, v.e_rdata, v.e_err, v.e_to,
            v.e_lat, v.e_acc);
      xfer(v);
    end

    cmd_valid = 1'b1;
    cmd_addr  = 32'h0000_0050;
    cmd_write = 1'b0;
    tick();
    cmd_valid  = 1'b0;
    apb_pready = 1'b0;
    repeat (2) tick();
    chk("pre_rst_access", {apb_psel, apb_penable}, 32'b11);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst", {apb_psel, apb_penable, rsp_valid, cmd_ready}, 32'd0);
    repeat (2) tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("ready_after_rst", {cmd_ready, apb_psel, rsp_valid}, 32'b100);
    chk("rst_cleared_addr", apb_paddr, 32'h0);
    xfer(tbl[0]);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/apb_cmd_master.md
# apb_cmd_master

Single-outstanding APB requester that sits directly upstream of the APB address decoder and drives its target-side APB port. Accepts read/write commands on a valid/ready channel, runs a SETUP/ACCESS APB transfer, and returns the read data and error status on a valid/ready response channel. A programmable timeout terminates transfers that never complete.

## Interface
- ADDR_W, 32, APB address width (paddr)
- DATA_W, 32, APB data width (pwdata/prdata, cmd_wdata, rsp_rdata)
- TIMEOUT, 255, max ACCESS-phase cycles before forced termination; 0 = timeout disabled
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
- cmd_addr  in  ADDR_W  byte address
- cmd_write  in  1  1 = write, 0 = read
- cmd_wdata  in  DATA_W  write data
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when rsp_valid & rsp_ready
- rsp_rdata  out  DATA_W  read data; 0 for writes and timeouts
- rsp_err  out  1  pslverr returned, or timeout
- rsp_timeout  out  1  transfer terminated by timeout
- apb_psel  out  1  APB select
- apb_penable  out  1  APB enable (ACCESS phase)
- apb_pwrite  out  1  APB direction
- apb_paddr  out  ADDR_W  APB address
- apb_pwdata  out  DATA_W  APB write data
- apb_pready  in  1  target completion
- apb_prdata  in  DATA_W  target read data
- apb_pslverr  in  1  target error

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP. Reset state IDLE.
- IDLE: cmd_ready = 1. On handshake, capture addr/write/wdata into registers; write data captured as 0 for reads; go SETUP.
- SETUP: psel=1, penable=0; always one cycle; go ACCESS; timeout counter cleared.
- ACCESS: psel=1, penable=1; counter increments each cycle pready=0. If pready=1: capture prdata (reads only, else 0) and pslverr into response registers, go RESP. Else if TIMEOUT≠0 and counter == TIMEOUT−1 (i.e. TIMEOUT ACCESS cycles without pready): rsp_err=1, rsp_timeout=1, rdata=0, go RESP.
- RESP: rsp_valid=1, psel=0, penable=0; hold response stable until rsp_ready; then IDLE.
- cmd_ready is 0 in SETUP, ACCESS, RESP (exactly one transfer outstanding).
- paddr/pwrite/pwdata driven from capture registers, stable from SETUP through last ACCESS cycle.
- Counter width: clog2(TIMEOUT+1) bits, saturates; never wraps.
- apb_pready / apb_pslverr / apb_prdata ignored outside ACCESS (late pready after timeout is dropped, no response generated).
- rsp_timeout=1 implies rsp_err=1; pslverr with pready yields rsp_err=1, rsp_timeout=0.

## Timing
- All outputs registered or decoded from state registers; no combinational path from apb_* or cmd_* inputs to any output.
- Reset values: cmd_ready=0 during reset, 1 in first cycle after release (IDLE); rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_timeout=0, psel=0, penable=0, pwrite=0, paddr=0, pwdata=0.
- Cycle T: cmd handshake. T+1: SETUP. T+2: first ACCESS. pready sampled high at cycle N≥T+2 → rsp_valid at N+1. Zero-wait target: rsp_valid at T+3.
- psel low for ≥1 cycle between transfers (RESP plus IDLE); the downstream decoder relies on psel dropping after pready.
- Minimum command-to-command spacing: 4 cycles (handshake, SETUP, ACCESS, RESP with rsp_ready=1).
- Reset asserted mid-transfer: psel/penable/rsp_valid drop asynchronously; pending command and response discarded.

## Test plan
- Write, zero-wait target: cmd addr=0x0000_0010, wdata=0xDEAD_BEEF → SETUP at T+1, ACCESS at T+2 with pwdata=0xDEAD_BEEF, pwrite=1; rsp_valid at T+3, rsp_err=0, rsp_rdata=0.
- Read through decoder to block B, target returns 0x1234_5678 after 3 wait states at addr 0x0100_0004 → psel held, address stable, rsp_rdata=0x1234_5678, rsp_err=0.
- Target pready with pslverr=1 on read → rsp_err=1, rsp_timeout=0, rsp_rdata=0x0 only if write else captured prdata.
- TIMEOUT=8, target never ready → exactly 8 ACCESS cycles, then psel=0, rsp_err=1, rsp_timeout=1, rsp_rdata=0; late pready in IDLE produces no response.
- Response backpressure: rsp_ready=0 for 5 cycles → rsp_valid and fields stable, cmd_ready=0, no new psel; accepted next command on first IDLE cycle after rsp_ready.
- rst_n asserted during ACCESS → psel, penable, rsp_valid 0 immediately; after release cmd_ready=1 and a fresh write completes normally.
